// File: rtl/rot4_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rot4_arb_pkg
//  Brief    : Shared widths and FSM state encoding for the rot4 arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package rot4_arb_pkg;

    localparam int DATA_W = 4;
    localparam int AMT_W  = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ROT  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

endpackage : rot4_arb_pkg
`default_nettype wire

// File: rtl/rot4_core.sv
`default_nettype none
// ============================================================================
//  Module   : rot4_core
//  Brief    : Combinational 4-bit rotate-right, two 2:1 mux stages (by 2, then by 1).
//  Revision : 1.0  initial release
// ============================================================================
module rot4_core
    import rot4_arb_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] w_stage1;

    assign w_stage1 = amt[1] ? {data[1:0], data[3:2]} : data;
    assign result   = amt[0] ? {w_stage1[0], w_stage1[3:1]} : w_stage1;

endmodule : rot4_core
`default_nettype wire

// File: rtl/rot4_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rot4_share_arbiter
//  Brief    : Round-robin share of one rotate-right datapath between two
//             requesters, registered response and per-requester done counters.
//  Revision : 1.0  initial release
// ============================================================================
module rot4_share_arbiter
    import rot4_arb_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [AMT_W-1:0]  req0_amt,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [AMT_W-1:0]  req1_amt,
    output logic              req1_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_id,
    output logic [CNT_W-1:0]  done0_cnt,
    output logic [CNT_W-1:0]  done1_cnt
);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_last_grant;
    logic              w_grant_vld;
    logic              w_grant_id;
    logic              w_resp_hs;
    logic [DATA_W-1:0] r_op;
    logic [AMT_W-1:0]  r_amt;
    logic              r_id;
    logic [DATA_W-1:0] w_rot;
    logic [DATA_W-1:0] r_resp_data;
    logic              r_resp_id;
    logic [CNT_W-1:0]  r_done0;
    logic [CNT_W-1:0]  r_done1;

    // Grant only in IDLE; a tie goes to the requester not served last.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = 1'b0;
        if (r_state == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = ~r_last_grant;
            end else if (req0_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = 1'b0;
            end else if (req1_valid) begin
                w_grant_vld = 1'b1;
                w_grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = w_grant_vld && !w_grant_id;
    assign req1_ready = w_grant_vld &&  w_grant_id;
    assign resp_valid = (r_state == ST_HOLD);
    assign w_resp_hs  = resp_valid && resp_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant_vld) w_state_nxt = ST_ROT;
            ST_ROT:  w_state_nxt = ST_HOLD;
            ST_HOLD: if (resp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    rot4_core u_core (
        .data   (r_op),
        .amt    (r_amt),
        .result (w_rot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_op         <= '0;
            r_amt        <= '0;
            r_id         <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= 1'b0;
            r_done0      <= '0;
            r_done1      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_vld) begin
                r_op         <= w_grant_id ? req1_data : req0_data;
                r_amt        <= w_grant_id ? req1_amt  : req0_amt;
                r_id         <= w_grant_id;
                r_last_grant <= w_grant_id;
            end
            if (r_state == ST_ROT) begin
                r_resp_data <= w_rot;
                r_resp_id   <= r_id;
            end
            if (w_resp_hs) begin
                if (r_resp_id) r_done1 <= r_done1 + 1'b1;
                else           r_done0 <= r_done0 + 1'b1;
            end
        end
    end

    assign resp_data = r_resp_data;
    assign resp_id   = r_resp_id;
    assign done0_cnt = r_done0;
    assign done1_cnt = r_done1;

endmodule : rot4_share_arbiter
`default_nettype wire

// File: tb/tb_rot4_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rot4_share_arbiter
//  Brief    : Directed self-checking bench with a response scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rot4_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, resp_ready;
    logic [3:0] req0_data, req1_data;
    logic [1:0] req0_amt, req1_amt;
    logic       req0_ready, req1_ready, resp_valid, resp_id;
    logic [3:0] resp_data;
    logic [7:0] done0_cnt, done1_cnt;

    logic       b_req0_valid;
    logic [3:0] b_req0_data;
    logic [1:0] b_req0_amt;
    logic       b_req0_ready, b_req1_ready, b_resp_valid, b_resp_id;
    logic [3:0] b_resp_data;
    logic [1:0] b_done0_cnt, b_done1_cnt;

    typedef struct packed {
        logic [3:0] data;
        logic       id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    rot4_share_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
        .done0_cnt(done0_cnt), .done1_cnt(done1_cnt)
    );

    rot4_share_arbiter #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_amt(b_req0_amt), .req0_ready(b_req0_ready),
        .req1_valid(1'b0), .req1_data(4'd0), .req1_amt(2'd0), .req1_ready(b_req1_ready),
        .resp_valid(b_resp_valid), .resp_ready(1'b1), .resp_data(b_resp_data), .resp_id(b_resp_id),
        .done0_cnt(b_done0_cnt), .done1_cnt(b_done1_cnt)
    );

    function automatic logic [3:0] rot_model(input logic [3:0] d, input logic [1:0] a);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = d[(i + int'(a)) % 4];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push on request handshake, pop on response handshake.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (req0_valid && req1_valid) chk("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (req0_valid && req0_ready) sb.push_back('{rot_model(req0_data, req0_amt), 1'b0});
            if (req1_valid && req1_ready) sb.push_back('{rot_model(req1_data, req1_amt), 1'b1});
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_data", {28'd0, resp_data}, {28'd0, e.data});
                    chk("sb_id", {31'd0, resp_id}, {31'd0, e.id});
                end
            end
        end
    end

    task automatic send(input logic id, input logic [3:0] d, input logic [1:0] a,
                        input logic [3:0] exp_data, input logic [7:0] exp_cnt);
        resp_ready = 1'b1;
        if (id) begin req1_valid = 1'b1; req1_data = d; req1_amt = a; end
        else    begin req0_valid = 1'b1; req0_data = d; req0_amt = a; end
        #1;
        chk("ready_granted", {31'd0, id ? req1_ready : req0_ready}, 32'd1);
        chk("ready_other", {31'd0, id ? req0_ready : req1_ready}, 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data  = ~d;   req1_data  = ~d;
        chk("rot_no_valid", {31'd0, resp_valid}, 32'd0);
        tick();
        chk("lat_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_data", {28'd0, resp_data}, {28'd0, exp_data});
        chk("resp_id", {31'd0, resp_id}, {31'd0, id});
        tick();
        chk("done_cnt", {24'd0, id ? done1_cnt : done0_cnt}, {24'd0, exp_cnt});
    endtask

    initial begin
        logic [7:0] base0, base1;
        int         n;
        rst = 1'b1;
        req0_valid = 0; req0_data = 0; req0_amt = 0;
        req1_valid = 0; req1_data = 0; req1_amt = 0;
        resp_ready = 0;
        b_req0_valid = 0; b_req0_data = 4'b0001; b_req0_amt = 2'd0;

        tick(); tick();
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_data", {28'd0, resp_data}, 32'd0);
        chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
        chk("rst_done0", {24'd0, done0_cnt}, 32'd0);
        chk("rst_done1", {24'd0, done1_cnt}, 32'd0);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        rst = 1'b0;
        tick();

        // Single-requester rotations
        send(1'b0, 4'b0001, 2'd1, 4'b1000, 8'd1);
        send(1'b0, 4'b0001, 2'd2, 4'b0100, 8'd2);
        send(1'b0, 4'b0001, 2'd3, 4'b0010, 8'd3);
        send(1'b0, 4'b1011, 2'd0, 4'b1011, 8'd4);
        send(1'b1, 4'b1100, 2'd1, 4'b0110, 8'd1);

        // Both requesters continuously valid: round-robin 0,1,0,1
        base0 = done0_cnt; base1 = done1_cnt;
        resp_ready = 1'b1;
        req0_valid = 1'b1; req0_data = 4'b1010; req0_amt = 2'd1;
        req1_valid = 1'b1; req1_data = 4'b0011; req1_amt = 2'd2;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (!(req0_ready || req1_ready) && n < 10) begin
                tick(); #1; n++;
            end
            chk("grant_timeout", {31'd0, n < 10}, 32'd1);
            chk("grant_order", {31'd0, req1_ready}, k % 2);
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick(); tick(); tick();
        chk("rr_done0", {24'd0, done0_cnt}, {24'd0, base0 + 8'd2});
        chk("rr_done1", {24'd0, done1_cnt}, {24'd0, base1 + 8'd2});

        // Backpressure in HOLD
        base0 = done0_cnt; base1 = done1_cnt;
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 4'b0110; req0_amt = 2'd3;
        tick();
        req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 4'b1111; req1_amt = 2'd1;
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_data", {28'd0, resp_data}, 32'b1100);
            chk("hold_id", {31'd0, resp_id}, 32'd0);
            chk("hold_ready0", {31'd0, req0_ready}, 32'd0);
            chk("hold_ready1", {31'd0, req1_ready}, 32'd0);
            chk("hold_cnt0", {24'd0, done0_cnt}, {24'd0, base0});
            tick();
        end
        req1_valid = 1'b0;
        resp_ready = 1'b1;
        tick();
        chk("hold_release_cnt0", {24'd0, done0_cnt}, {24'd0, base0 + 8'd1});
        chk("hold_release_cnt1", {24'd0, done1_cnt}, {24'd0, base1});

        // Reset during ROT discards the transaction
        req0_valid = 1'b1; req0_data = 4'b0101; req0_amt = 2'd1;
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_done0", {24'd0, done0_cnt}, 32'd0);
        chk("mid_rst_done1", {24'd0, done1_cnt}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            chk("mid_rst_no_resp", {31'd0, resp_valid}, 32'd0);
            tick();
        end

        // Counter wrap on the CNT_W=2 instance: five responses -> 1
        b_req0_valid = 1'b1;
        #1;
        chk("w2_ready0", {31'd0, b_req0_ready}, 32'd1);
        for (int c = 0; c < 13; c++) tick();
        b_req0_valid = 1'b0;
        tick(); tick();
        chk("w2_wrap_done0", {30'd0, b_done0_cnt}, 32'd1);
        chk("w2_done1", {30'd0, b_done1_cnt}, 32'd0);
        chk("w2_idle_valid", {31'd0, b_resp_valid}, 32'd0);
        chk("w2_last_data", {28'd0, b_resp_data}, 32'b0001);
        chk("w2_last_id", {31'd0, b_resp_id}, 32'd0);
        chk("w2_ready1", {31'd0, b_req1_ready}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rot4_share_arbiter
`default_nettype wire
